// File: rtl/t_toggle_rx.sv
// ---------------------------------------------------------------------------
// t_toggle_rx
//   Receive end of the toggle-signalling link. The remote source flips t_in
//   once per event. t_in is synchronised into the clk domain, and every
//   change of the synchronised level counts as one event. Each event
//   produces a one-cycle pulse, bumps a wrapping event counter and adds a
//   credit to a ready/valid credit queue that downstream logic drains.
//
// Parameters
//   SYNC_STAGES  flops in the t_in synchroniser chain (>= 2)
//   CNT_W        width of evt_count (wraps)
//   PEND_W       width of the pending credit counter (saturates at all-ones)
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   t_in       in   asynchronous toggle level from the remote source
//   clr_ovf    in   synchronous clear of the sticky overflow flag
//   evt_ready  in   downstream accepts one credit (when evt_valid is high)
//   evt_valid  out  at least one credit pending
//   evt_pulse  out  one-cycle pulse per detected toggle
//   t_level    out  synchronised t_in level (last sync stage)
//   evt_count  out  toggles detected since reset
//   pending    out  credits not yet accepted
//   overflow   out  sticky: a toggle arrived while pending was full
// ---------------------------------------------------------------------------
module t_toggle_rx #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned PEND_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              t_in,
    input  logic              clr_ovf,
    input  logic              evt_ready,
    output logic              evt_valid,
    output logic              evt_pulse,
    output logic              t_level,
    output logic [CNT_W-1:0]  evt_count,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam logic ST_ARM = 1'b0;
    localparam logic ST_RUN = 1'b1;

    localparam int unsigned ARM_W = $clog2(SYNC_STAGES + 1);
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(SYNC_STAGES - 1);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("t_toggle_rx: SYNC_STAGES must be at least 2");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   state_q,   state_d;
    logic [ARM_W-1:0]       arm_cnt_q, arm_cnt_d;
    logic                   t_ref_q,   t_ref_d;
    logic                   pulse_q,   pulse_d;
    logic [CNT_W-1:0]       cnt_q,     cnt_d;
    logic [PEND_W-1:0]      pend_q,    pend_d;
    logic                   valid_q,   valid_d;
    logic                   ovf_q,     ovf_d;

    logic sync_out;
    logic toggle;
    logic pop;
    logic ovf_set;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d   = state_q;
        arm_cnt_d = arm_cnt_q;
        t_ref_d   = t_ref_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        toggle    = 1'b0;
        ovf_set   = 1'b0;
        pop       = valid_q & evt_ready;

        if (state_q == ST_ARM) begin
            arm_cnt_d = arm_cnt_q + ARM_W'(1);
            if (arm_cnt_q == ARM_LAST) begin
                // Reference is taken from the value entering the last stage on
                // this edge, so it equals sync_out as RUN begins; a level that
                // was already high through reset is not seen as a change.
                t_ref_d   = sync_q[SYNC_STAGES-2];
                arm_cnt_d = '0;
                state_d   = ST_RUN;
            end
        end else begin
            toggle = (sync_out != t_ref_q);
        end

        if (toggle) begin
            t_ref_d = sync_out;
            cnt_d   = cnt_q + CNT_W'(1);
        end
        pulse_d = toggle;

        if (toggle && !pop) begin
            if (pend_q == '1) begin
                ovf_set = 1'b1;
            end else begin
                pend_d = pend_q + PEND_W'(1);
            end
        end else if (!toggle && pop) begin
            pend_d = pend_q - PEND_W'(1);
        end

        valid_d = (pend_d != '0);
        // Set has priority over clear.
        ovf_d   = ovf_set | (ovf_q & ~clr_ovf);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            state_q   <= ST_ARM;
            arm_cnt_q <= '0;
            t_ref_q   <= 1'b0;
            pulse_q   <= 1'b0;
            cnt_q     <= '0;
            pend_q    <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], t_in};
            state_q   <= state_d;
            arm_cnt_q <= arm_cnt_d;
            t_ref_q   <= t_ref_d;
            pulse_q   <= pulse_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
        end
    end

    assign t_level   = sync_out;
    assign evt_pulse = pulse_q;
    assign evt_count = cnt_q;
    assign pending   = pend_q;
    assign evt_valid = valid_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_t_toggle_rx.sv
// ---------------------------------------------------------------------------
// tb_t_toggle_rx
//   Directed bench for t_toggle_rx with default parameters (2 sync stages,
//   8-bit count, 4-bit pending). A per-cycle vector table covers reset, ARM
//   and first-event latency; hand-written sequences cover draining,
//   saturation/overflow, clear priority, count wrap and async reset.
// ---------------------------------------------------------------------------
module tb_t_toggle_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       t_in;
    logic       clr_ovf;
    logic       evt_ready;
    logic       evt_valid;
    logic       evt_pulse;
    logic       t_level;
    logic [7:0] evt_count;
    logic [3:0] pending;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    t_toggle_rx #(
        .SYNC_STAGES(2),
        .CNT_W      (8),
        .PEND_W     (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .t_in     (t_in),
        .clr_ovf  (clr_ovf),
        .evt_ready(evt_ready),
        .evt_valid(evt_valid),
        .evt_pulse(evt_pulse),
        .t_level  (t_level),
        .evt_count(evt_count),
        .pending  (pending),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       t;
        logic       rdy;
        logic       clr;
        logic       pulse;
        logic       level;
        logic [7:0] cnt;
        logic [3:0] pend;
        logic       valid;
        logic       ovf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic t, input logic rdy,
                                input logic clr, input logic pulse, input logic level,
                                input logic [7:0] cnt, input logic [3:0] pend,
                                input logic valid, input logic ovf);
        vec_t v;
        v.rst = r;  v.t = t;  v.rdy = rdy;  v.clr = clr;
        v.pulse = pulse;  v.level = level;  v.cnt = cnt;
        v.pend = pend;  v.valid = valid;  v.ovf = ovf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic tv);
        rst = 1'b1; t_in = tv; evt_ready = 1'b0; clr_ovf = 1'b0;
        step();
        step();
        rst = 1'b0;
        repeat (4) step();
    endtask

    // Flip t_in and run 4 cycles, returning how many cycles evt_pulse was high.
    task automatic toggle_win(output int pulses);
        pulses = 0;
        t_in = ~t_in;
        repeat (4) begin
            step();
            if (evt_pulse) pulses++;
        end
    endtask

    initial begin
        int np;
        rst = 1'b1; t_in = 1'b1; evt_ready = 1'b0; clr_ovf = 1'b0;

        //              rst t   rdy clr  pulse lvl cnt pend valid ovf
        // Test 1: t_in high through reset, ARM must not create an event.
        tbl.push_back(mk(1, 1, 0, 0,   0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0,   0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,   0, 0, 0, 0, 0, 0));  // ARM edge 1
        tbl.push_back(mk(0, 1, 0, 0,   0, 1, 0, 0, 0, 0));  // ARM edge 2
        tbl.push_back(mk(0, 1, 0, 0,   0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,   0, 1, 0, 0, 0, 0));
        // Test 2: restart with t_in low, then 0->1; pulse after 3rd edge.
        tbl.push_back(mk(1, 0, 0, 0,   0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,   0, 0, 0, 0, 0, 0));  // edge N
        tbl.push_back(mk(0, 1, 0, 0,   0, 1, 0, 0, 0, 0));  // edge N+1
        tbl.push_back(mk(0, 1, 0, 0,   1, 1, 1, 1, 1, 0));  // edge N+2
        tbl.push_back(mk(0, 1, 0, 0,   0, 1, 1, 1, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0,   0, 1, 1, 1, 1, 0));

        foreach (tbl[i]) begin
            rst = tbl[i].rst; t_in = tbl[i].t;
            evt_ready = tbl[i].rdy; clr_ovf = tbl[i].clr;
            step();
            chk($sformatf("vec%0d", i),
                {13'd0, evt_pulse, t_level, evt_count, pending, evt_valid, overflow},
                {13'd0, tbl[i].pulse, tbl[i].level, tbl[i].cnt, tbl[i].pend,
                 tbl[i].valid, tbl[i].ovf});
        end

        // Test 3: 5 toggles without draining, then drain 5 credits.
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) begin
            toggle_win(np);
            chk($sformatf("t3_pulse_once%0d", i), np, 1);
        end
        chk("t3_count", evt_count, 5);
        chk("t3_pending", pending, 5);
        chk("t3_valid", evt_valid, 1);
        evt_ready = 1'b1;
        repeat (4) step();
        chk("t3_pending_1left", pending, 1);
        step();
        chk("t3_drained", {evt_valid, pending}, 5'h00);
        repeat (2) step();
        chk("t3_no_underflow", {evt_valid, pending}, 5'h00);
        evt_ready = 1'b0;

        // Test 4: saturate at 15 and raise overflow on the 16th toggle.
        do_reset(1'b0);
        for (int i = 0; i < 15; i++) toggle_win(np);
        chk("t4_pend15", pending, 15);
        chk("t4_no_ovf_yet", overflow, 0);
        toggle_win(np);
        chk("t4_ovf", overflow, 1);
        chk("t4_pend_hold", pending, 15);
        chk("t4_count16", evt_count, 16);
        chk("t4_pulse_at_full", np, 1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("t4_clr", {overflow, pending}, 5'h0F);

        // Overflow set and clear in the same cycle: set wins.
        clr_ovf = 1'b1;
        t_in = ~t_in;
        repeat (3) step();
        clr_ovf = 1'b0;
        chk("t4_set_wins", overflow, 1);
        chk("t4_count17", evt_count, 17);
        step();
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("t4_clr2", overflow, 0);

        // Test 5: toggle and pop together at full: no change, no overflow.
        t_in = ~t_in;
        repeat (2) step();
        evt_ready = 1'b1;          // detection edge
        step();
        evt_ready = 1'b0;
        chk("t5_pulse", evt_pulse, 1);
        chk("t5_pend15", pending, 15);
        chk("t5_no_ovf", overflow, 0);
        chk("t5_count18", evt_count, 18);
        step();

        // Test 6: 256 toggles while draining; count wraps to 0.
        do_reset(1'b1);
        evt_ready = 1'b1;
        for (int i = 0; i < 256; i++) toggle_win(np);
        chk("t6_wrap", evt_count, 0);
        chk("t6_drained", {evt_valid, pending}, 5'h00);
        evt_ready = 1'b0;
        for (int i = 0; i < 3; i++) toggle_win(np);
        chk("t6_pend3", pending, 3);
        chk("t6_count3", evt_count, 3);

        // Async reset mid-cycle: outputs clear before any clock edge.
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_rst",
            {evt_pulse, t_level, evt_count, pending, evt_valid, overflow}, 16'h0000);
        step();
        rst = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
